// File: rtl/rt_ibex_pcs_pkg.sv
// Shared definitions for the preemptive context save (PCS) register-file sequencer.
//   - pcs_state_e      : sequencer FSM states
//   - NrSavedRegsDefault: registers per saved context
//   - SavedRegAddr     : RF addresses of the saved registers, in context (table) order
//   - saved_reg_addr() : safe lookup into SavedRegAddr
package rt_ibex_pcs_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StStore,
        StWaitPop,
        StWriteback
    } pcs_state_e;

    localparam int unsigned NrSavedRegsDefault = 9;
    localparam int unsigned SavedRegAddrWidth  = 5;

    // Caller-saved registers: ra, t0-t2, a0-a4.
    localparam logic [SavedRegAddrWidth-1:0] SavedRegAddr [NrSavedRegsDefault] = '{
        5'd1, 5'd5, 5'd6, 5'd7, 5'd10, 5'd11, 5'd12, 5'd13, 5'd14
    };

    function automatic logic [SavedRegAddrWidth-1:0] saved_reg_addr(input int unsigned idx);
        logic [SavedRegAddrWidth-1:0] addr;
        addr = '0;
        if (idx < NrSavedRegsDefault) begin
            addr = SavedRegAddr[idx];
        end
        return addr;
    endfunction

endpackage

// File: rtl/rt_ibex_pcs_rf_seq.sv
// Core-side sequencer for the PCS LIFO stack.
// On an interrupt acknowledge the saved registers are snapshotted and pushed to the stack.
// On mret one context is popped and written back through the single RF write port, one
// register per cycle, while the core is stalled.
//
// Ports:
//   clk_i, rst_ni            clock, asynchronous active-low reset
//   irq_ack_i, mret_i        core events, single-cycle pulses, honoured only while ready_o
//   ready_o, stall_o         sequencer idle / freeze core issue during restore
//   rf_snapshot_i            current saved-register values (table order)
//   rf_we_o/waddr_o/wdata_o  RF write port used during writeback
//   stack_irq_ack_o          push request, stack_store_data_o carries the context
//   stack_next_mret_o        pop request, answered by stack_restore_en_i/stack_restore_data_i
//   err_overflow_o           pulse: push while the stack is full
//   err_underflow_o          pulse: mret while the stack is empty
//
// Configuration macro RT_IBEX_PCS_DEPTH_CHECK_EN: when defined, a depth counter tracks the
// stack occupancy, flags overflow/underflow and suppresses pops from an empty stack.
// When undefined, both error outputs are tied low and every accepted mret pops.
module rt_ibex_pcs_rf_seq
    import rt_ibex_pcs_pkg::*;
#(
    parameter int unsigned NrSavedRegs  = NrSavedRegsDefault,
    parameter int unsigned DataWidth    = 32,
    parameter int unsigned StackDepth   = 8,
    parameter int unsigned RegAddrWidth = 5
) (
    input  logic                                  clk_i,
    input  logic                                  rst_ni,
    input  logic                                  irq_ack_i,
    input  logic                                  mret_i,
    output logic                                  ready_o,
    output logic                                  stall_o,
    input  logic [NrSavedRegs-1:0][DataWidth-1:0] rf_snapshot_i,
    output logic                                  rf_we_o,
    output logic [RegAddrWidth-1:0]               rf_waddr_o,
    output logic [DataWidth-1:0]                  rf_wdata_o,
    output logic                                  stack_irq_ack_o,
    output logic                                  stack_next_mret_o,
    output logic [NrSavedRegs-1:0][DataWidth-1:0] stack_store_data_o,
    input  logic [NrSavedRegs-1:0][DataWidth-1:0] stack_restore_data_i,
    input  logic                                  stack_restore_en_i,
    output logic                                  err_overflow_o,
    output logic                                  err_underflow_o
);

    localparam int unsigned IdxWidth   = (NrSavedRegs > 1) ? $clog2(NrSavedRegs) : 1;
    localparam int unsigned DepthWidth = $clog2(StackDepth + 1);

    pcs_state_e                            state_q;
    logic [NrSavedRegs-1:0][DataWidth-1:0] buffer_q;
    logic [IdxWidth-1:0]                   idx_q;

    logic idle;
    logic push_take;
    logic pop_take;
    logic pop_allowed;
    logic last_idx;

`ifdef RT_IBEX_PCS_DEPTH_CHECK_EN
    logic [DepthWidth-1:0] depth_q;
    logic                  stack_full;

    assign stack_full  = (depth_q == DepthWidth'(StackDepth));
    assign pop_allowed = (depth_q != '0);
`else
    // Depth is not tracked in this build; keep the parameter referenced.
    logic unused_depth_cfg;
    assign unused_depth_cfg = (DepthWidth == 0);
    assign pop_allowed      = 1'b1;
`endif

    assign idle      = (state_q == StIdle);
    // The acknowledge wins over a simultaneous mret; the core re-executes mret later.
    assign push_take = idle && irq_ack_i;
    assign pop_take  = idle && mret_i && !irq_ack_i && pop_allowed;
    assign last_idx  = (idx_q == IdxWidth'(NrSavedRegs - 1));

    always_comb begin
        ready_o            = idle;
        stack_irq_ack_o    = push_take;
        stack_next_mret_o  = pop_take;
        stall_o            = pop_take || (state_q == StWaitPop) || (state_q == StWriteback);
        rf_we_o            = (state_q == StWriteback);
        rf_waddr_o         = '0;
        rf_wdata_o         = '0;
        stack_store_data_o = buffer_q;
        if (rf_we_o) begin
            rf_waddr_o = RegAddrWidth'(saved_reg_addr(32'(idx_q)));
            rf_wdata_o = buffer_q[idx_q];
        end
`ifdef RT_IBEX_PCS_DEPTH_CHECK_EN
        err_overflow_o  = push_take && stack_full;
        err_underflow_o = idle && mret_i && !irq_ack_i && !pop_allowed;
`else
        err_overflow_o  = 1'b0;
        err_underflow_o = 1'b0;
`endif
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= StIdle;
            buffer_q <= '0;
            idx_q    <= '0;
`ifdef RT_IBEX_PCS_DEPTH_CHECK_EN
            depth_q  <= '0;
`endif
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (push_take) begin
                        buffer_q <= rf_snapshot_i;
                        state_q  <= StStore;
                    end else if (pop_take) begin
                        state_q  <= StWaitPop;
                    end
                end
                StStore: begin
                    state_q <= StIdle;
                end
                StWaitPop: begin
                    if (stack_restore_en_i) begin
                        buffer_q <= stack_restore_data_i;
                        idx_q    <= '0;
                        state_q  <= StWriteback;
                    end
                end
                StWriteback: begin
                    // Index holds at the last entry; it is cleared on the next restore.
                    if (last_idx) begin
                        state_q <= StIdle;
                    end else begin
                        idx_q <= idx_q + 1'b1;
                    end
                end
                default: state_q <= StIdle;
            endcase
`ifdef RT_IBEX_PCS_DEPTH_CHECK_EN
            // A full stack drops its oldest entry, so occupancy saturates.
            if (push_take && !stack_full) begin
                depth_q <= depth_q + 1'b1;
            end else if (pop_take) begin
                depth_q <= depth_q - 1'b1;
            end
`endif
        end
    end

endmodule

// File: doc/rt_ibex_pcs_rf_seq.md
# rt_ibex_pcs_rf_seq

Core-side sequencer for the preemptive context save (PCS) LIFO stack. On an interrupt acknowledge it snapshots the caller-saved registers and pushes them to the stack. On `mret` it pops one context and writes it back into the register file through the single RF write port, one register per cycle, stalling the core until writeback completes. It sits between the ID/controller stage, the register file and the PCS stack.

## Interface
Parameters:
- NrSavedRegs, 9: registers per context; must equal the stack's value.
- DataWidth, 32: register width.
- StackDepth, 8: number of stack entries; must equal the stack's depth.
- RegAddrWidth, 5: RF address width.

Ports:
- clk_i  in  1  clock, rising edge.
- rst_ni  in  1  reset; asynchronous, active-low.
- irq_ack_i  in  1  core accepts an interrupt; single-cycle pulse.
- mret_i  in  1  `mret` retires; single-cycle pulse.
- ready_o  out  1  sequencer in IDLE; the core issues `irq_ack_i`/`mret_i` only while this is high.
- stall_o  out  1  freezes core issue during restore.
- rf_snapshot_i  in  NrSavedRegs×DataWidth  current values of the saved registers, in table order.
- rf_we_o  out  1  RF write enable.
- rf_waddr_o  out  RegAddrWidth  RF write address.
- rf_wdata_o  out  DataWidth  RF write data.
- stack_irq_ack_o  out  1  push request to the stack.
- stack_next_mret_o  out  1  pop request to the stack.
- stack_store_data_o  out  NrSavedRegs×DataWidth  context to push.
- stack_restore_data_i  in  NrSavedRegs×DataWidth  popped context.
- stack_restore_en_i  in  1  single-cycle strobe; `stack_restore_data_i` is valid only in this cycle.
- err_overflow_o  out  1  pulse: push while the stack is full.
- err_underflow_o  out  1  pulse: `mret` while the stack is empty.

## Operation
FSM states: IDLE, STORE, WAIT_POP, WRITEBACK.

- **IDLE.** `ready_o` = 1.
  - `irq_ack_i` → `stack_irq_ack_o` = 1 combinationally in the same cycle; `rf_snapshot_i` is captured into the context buffer; next state STORE.
  - `mret_i` (and no `irq_ack_i`) → `stack_next_mret_o` = 1 combinationally; `stall_o` = 1; next state WAIT_POP.
  - `irq_ack_i` and `mret_i` in the same cycle → the ack wins and `mret_i` is dropped. The core re-executes `mret` after the handler.
- **STORE** (1 cycle). The buffer drives `stack_store_data_o` while the stack writes. Next state IDLE.
- **WAIT_POP.** `stall_o` = 1.
  - On `stack_restore_en_i`: capture `stack_restore_data_i` into the buffer; clear the index counter; next state WRITEBACK.
  - `stack_restore_en_i` arriving in any other state is ignored.
- **WRITEBACK** (NrSavedRegs cycles). `rf_we_o` = 1, `rf_waddr_o` = SavedRegAddr[idx], `rf_wdata_o` = buffer[idx]; idx increments each cycle. After idx = NrSavedRegs−1, next state IDLE.
- The counter is $clog2(NrSavedRegs) bits and never wraps past NrSavedRegs−1.
- `irq_ack_i` or `mret_i` outside IDLE is a protocol violation. It is ignored and produces no stack request.
- `stack_store_data_o` always drives the buffer contents.

## Timing
- Reset: FSM = IDLE, buffer = 0, depth = 0, idx = 0. All outputs 0 except `ready_o` = 1.
- Reset asserted mid-operation aborts immediately. A partially written-back context is not resumed.
- Push: ack at cycle T; stack write at T+1; `ready_o` returns at T+2.
- Pop: `mret` at T; `stack_restore_en_i` expected at T+2; writes at T+3 … T+2+NrSavedRegs.
- `stall_o` is high from T through T+2+NrSavedRegs inclusive.
- `ready_o` returns at T+3+NrSavedRegs.

## Configuration
- Macro `RT_IBEX_PCS_DEPTH_CHECK_EN` defined:
  - A depth counter (0..StackDepth) increments on push and decrements on pop.
  - Push at depth = StackDepth: still forwarded (the oldest context is lost), `err_overflow_o` pulses, depth saturates.
  - `mret_i` at depth 0: no `stack_next_mret_o`, no stall, FSM stays IDLE, `err_underflow_o` pulses.
- Macro not defined: no counter; both error outputs are tied 0; every accepted `mret_i` issues a pop.

## Structure
- Package `rt_ibex_pcs_pkg` holds:
  - the state enum;
  - the default NrSavedRegs;
  - the constant `SavedRegAddr` = {x1, x5, x6, x7, x10, x11, x12, x13, x14}.
- No sub-module. The stack is instantiated beside this block at the parent level.

## Test plan
- **Single push/pop.** Snapshot regs = 0x1000+i, ack, then `mret`. Expect `stack_store_data_o` valid at T+1, then 9 writes to x1…x14 with 0x1000…0x1008 on consecutive cycles, `stall_o` high for 12 cycles.
- **Nested.** Push A, push B, `mret`, `mret`. Expect B restored, then A.
- **Simultaneous.** `irq_ack_i` and `mret_i` in the same cycle. Expect a push only, no `stack_next_mret_o`, FSM in STORE.
- **Overflow/underflow** (macro on). 9 pushes: expect `err_overflow_o` on the 9th. Reset, then `mret`: expect `err_underflow_o`, no stall. With the macro off, both outputs stay 0.
- **Reset mid-writeback.** Assert `rst_ni` low at the 4th write. Expect `rf_we_o` = 0 at once and `ready_o` = 1 after release.
- **Protocol violation.** `irq_ack_i` during WRITEBACK. Expect no `stack_irq_ack_o` and writeback unaffected.
